// File: rtl/mdu_pkg.sv
// Shared types, constants and op-decode helpers for the iterative multiply/divide unit.
// Latency/backpressure are properties of mult_div_unit; this package holds no logic state.
package mdu_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'b00,
      MULTU = 2'b01,
      DIV   = 2'b10,
      DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mdu_state_t;

   localparam int          MDU_ITERS     = 32;
   localparam int          MDU_CNT_W     = $clog2(MDU_ITERS);
   localparam logic [31:0] MDU_DIVZERO_Q = 32'hFFFF_FFFF;

   function automatic logic mdu_is_div(input mdu_op_t o);
      return o[1];
   endfunction

   function automatic logic mdu_is_signed(input mdu_op_t o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: LSB-first shift-add for multiply, MSB-first restoring
// shift-subtract for divide, sharing a single 33-bit adder. Zero latency, no flow control.
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opb,
   input  logic               is_div,
   input  logic               bit_in,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   add_y;
   logic [WIDTH+1:0] sum;
   logic             geq;

   always_comb begin
      // Divide computes x + ~b + 1; its carry-out is the "remainder >= divisor" flag.
      add_x = is_div ? {acc[2*WIDTH-1:WIDTH], bit_in} : {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_y = is_div ? ~{1'b0, opb} : (bit_in ? {1'b0, opb} : '0);
      sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, is_div};
      geq   = sum[WIDTH+1];
      if (!is_div) begin
         acc_nxt = {sum[WIDTH:0], acc[WIDTH-1:1]};
      end else if (geq) begin
         acc_nxt = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt = {add_x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: done pulses 34 cycles after start is accepted.
// No backpressure: start is ignored while busy; hi/lo hold from one done to the next.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_t             state_q, state_d;
   mdu_op_t                op_q, op_d;
   logic                   neg_a_q, neg_a_d;
   logic                   neg_b_q, neg_b_d;
   logic [WIDTH-1:0]       a_q, a_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]       hi_q, hi_d;
   logic [WIDTH-1:0]       lo_q, lo_d;

   logic [2*WIDTH-1:0]     acc_nxt;
   logic                   step_div;
   logic                   step_bit;
   logic [WIDTH-1:0]       quo;
   logic [WIDTH-1:0]       rem;
   logic [2*WIDTH-1:0]     prod;

   // a_q is a shift register feeding one operand-A bit per iteration.
   assign step_div = mdu_is_div(op_q);
   assign step_bit = step_div ? a_q[WIDTH-1] : a_q[0];

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc_q),
      .opb     (b_q),
      .is_div  (step_div),
      .bit_in  (step_bit),
      .acc_nxt (acc_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= MULT;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (cnt_q == MDU_CNT_W'(MDU_ITERS - 1)) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_d    = op_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      quo     = acc_q[WIDTH-1:0];
      rem     = acc_q[2*WIDTH-1:WIDTH];
      prod    = acc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = mdu_op_t'(op);
               neg_a_d = mdu_is_signed(mdu_op_t'(op)) & rs[WIDTH-1];
               neg_b_d = mdu_is_signed(mdu_op_t'(op)) & rt[WIDTH-1];
               a_d     = neg_a_d ? -rs : rs;
               b_d     = neg_b_d ? -rt : rt;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         CALC: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + MDU_CNT_W'(1);
            a_d   = step_div ? (a_q << 1) : (a_q >> 1);
         end
         FIX: begin
            if (step_div) begin
               // Divide-by-zero leaves |rs| as remainder, which the dividend-sign fix turns back into rs.
               if (neg_a_q ^ neg_b_q) quo = -quo;
               if (neg_a_q) rem = -rem;
               if (b_q == '0) quo = MDU_DIVZERO_Q;
               hi_d = rem;
               lo_d = quo;
            end else begin
               if (neg_a_q ^ neg_b_q) prod = -prod;
               {hi_d, lo_d} = prod;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      hi   = hi_q;
      lo   = lo_q;
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases, busy/reset behaviour, random ops.
module tb_mult_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_vec;
   int          n_bad;
   int          cyc;
   int          done_cnt;
   logic        pulse_chk;
   logic [63:0] last_res;
   logic [63:0] exp_q[$];
   int          acc_cyc_q[$];

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] res;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      res = '0;
      case (o)
         2'b00: res = sa * sb;
         2'b01: res = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Scoreboard consumer: every done pops one expectation and checks value and latency.
   always @(negedge clk) begin
      if (pulse_chk) begin
         chk_eq("done_width", {63'd0, done}, 64'd0);
         pulse_chk = 1'b0;
      end else if (done) begin
         done_cnt++;
         pulse_chk = 1'b1;
         if (exp_q.size() == 0) begin
            chk_eq("spurious_done", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            int c;
            e = exp_q.pop_front();
            c = acc_cyc_q.pop_front();
            chk_eq("hi", {32'd0, hi}, {32'd0, e[63:32]});
            chk_eq("lo", {32'd0, lo}, {32'd0, e[31:0]});
            chk_eq("latency", 64'(cyc - c), 64'd33);
            last_res = e;
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom_range(0, 3));
      rs    = $urandom;
      rt    = $urandom;
      exp_q.push_back(exp);
      acc_cyc_q.push_back(cyc);
      chk_eq("busy_on_accept", {63'd0, busy}, 64'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      if (!done) chk_eq("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      cyc       = 0;
      done_cnt  = 0;
      pulse_chk = 1'b0;
      last_res  = '0;
      rst_n     = 1'b0;
      start     = 1'b0;
      op        = 2'b00;
      rs        = '0;
      rt        = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("rst_busy", {63'd0, busy}, 64'd0);
      chk_eq("rst_done", {63'd0, done}, 64'd0);
      chk_eq("rst_hi", {32'd0, hi}, 64'd0);
      chk_eq("rst_lo", {32'd0, lo}, 64'd0);
      rst_n = 1'b1;

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      wait_done();

      // A second start mid-operation must be ignored.
      issue(2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
      repeat (9) @(negedge clk);
      chk_eq("hold_mid_op", {hi, lo}, last_res);
      start = 1'b1;
      op    = 2'b11;
      rs    = 32'd1000;
      rt    = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();

      // Issued in the cycle right after done.
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      wait_done();
      issue(2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
      wait_done();

      // Reset mid-divide aborts without a done pulse.
      issue(2'b11, 32'h1234_5678, 32'd9, 64'd0);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      void'(exp_q.pop_back());
      void'(acc_cyc_q.pop_back());
      chk_eq("abort_busy", {63'd0, busy}, 64'd0);
      chk_eq("abort_hilo", {hi, lo}, 64'd0);
      rst_n = 1'b1;
      begin
         int d0;
         d0 = done_cnt;
         repeat (40) @(negedge clk);
         chk_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
      end
      issue(2'b01, 32'd6, 32'd7, 64'd42);
      wait_done();

      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
      wait_done();
      issue(2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      wait_done();
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      wait_done();
      issue(2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
      wait_done();

      for (int i = 0; i < 16; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         o = 2'(i % 4);
         a = $urandom;
         b = (i >= 8) ? 32'($urandom_range(1, 5000)) : $urandom;
         issue(o, a, b, model(o, a, b));
         wait_done();
      end

      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk_eq("drain", 64'(exp_q.size()), 64'd0);
      end
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit executing MIPS MULT, MULTU, DIV and DIVU. Sits directly upstream of the HI/LO register block. It accepts two 32-bit operands from the register-read stage and produces a 64-bit {hi, lo} result after a fixed latency. A one-cycle `done` pulse tells the HI/LO write logic when to capture the result.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported and verified.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  input  1  request; accepted only when `busy` is low.
- `op`  input  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `rs`  input  32  operand A (multiplicand / dividend).
- `rt`  input  32  operand B (multiplier / divisor).
- `busy`  output  1  high while an operation is in flight, up to and including the `done` cycle.
- `done`  output  1  single-cycle pulse; `hi`/`lo` are valid from this cycle onward.
- `hi`  output  32  product[63:32], or remainder for divides.
- `lo`  output  32  product[31:0], or quotient for divides.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - On `start`=1: latch `op`, sign flags, and absolute values of `rs`/`rt`.
  - Absolute values are taken only for signed ops; unsigned ops latch operands as-is.
  - Clear the 64-bit accumulator and the 5-bit iteration counter, then go to CALC.
- **CALC**: one iteration per cycle, 32 cycles; the counter counts 0..31, and the last count moves to FIX.
  - Multiply: shift-add, LSB-first.
  - Divide: restoring shift-subtract, MSB-first.
  - All arithmetic is unsigned on magnitudes, using a 33-bit subtractor/adder.
- **FIX**: apply sign correction, then register the result into `hi`/`lo`.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if signs differ; the remainder takes the sign of the dividend.
- **DONE**: `done`=1 for exactly one cycle, then return to IDLE.
- `start` is ignored while `busy`=1, including during DONE. Operands need only be valid in the accepting cycle.
- Divide by zero, any signedness: `lo`=32'hFFFF_FFFF, `hi`=`rs` (original, unmodified). No exception is raised, and latency is unchanged.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: `lo`=32'h8000_0000, `hi`=0 (two's-complement wrap, no trap).
- `hi`/`lo` hold their value from one `done` until the next `done`; they are never updated mid-operation.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and accumulator cleared.
- Reset mid-operation aborts it; the result is discarded and no `done` is produced.
- Let start be accepted at edge E0. Then:
  - CALC occupies the cycles after E0..E31.
  - FIX occupies the cycle after E32.
  - `done`=1 in the cycle after E33, with `hi`/`lo` valid in that same cycle.
  - A new `start` can be accepted at E34, giving a minimum issue interval of 34 cycles.
- `busy`=1 from the cycle after E0 through the `done` cycle inclusive. `busy` is registered, never combinational from `start`.
- Downstream rule: the HI/LO block writes `hi` then `lo`, or both, on `done`. Each write is keyed only on `done`, with no dependency on `busy`.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op_t` enum (MULT, MULTU, DIV, DIVU).
  - `mdu_state_t` enum (IDLE, CALC, FIX, DONE).
  - `MDU_ITERS`=32.
  - `MDU_DIVZERO_Q`=32'hFFFF_FFFF.
- One natural sub-module, `mdu_step`: purely combinational single iteration.
  - Inputs: accumulator, operand B, mode.
  - Output: next accumulator.
  - Shared by multiply and divide; instantiated once.
- The top module holds the FSM, counter, sign flags and output registers.

## Test plan
- MULTU rs=32'hFFFF_FFFF, rt=32'hFFFF_FFFF -> `done` 34 cycles after accept; `hi`=32'hFFFF_FFFE, `lo`=32'h0000_0001.
- MULT rs=-3 (32'hFFFF_FFFD), rt=7 -> `hi`=32'hFFFF_FFFF, `lo`=32'hFFFF_FFEB.
- DIV rs=-7, rt=2 -> `lo`=32'hFFFF_FFFD (-3), `hi`=32'hFFFF_FFFF (-1).
- DIVU rs=100, rt=0 -> `lo`=32'hFFFF_FFFF, `hi`=100, latency still 34.
- Re-issue `start` while busy (cycle 10) with different operands -> ignored; result matches the first operation. Next `start` in the cycle after `done` is accepted.
- Assert `rst_n`=0 at cycle 15 of a DIVU -> `busy`=0, `hi`=`lo`=0 next cycle, no `done` pulse. A fresh MULTU 6×7 then gives `lo`=42, `hi`=0.
